// File: rtl/servo_pwm_capture.sv
// Servo PWM capture: measures the high time and rise-to-rise period of an
// asynchronous servo pulse train in prescaled ticks, with range and timeout flags.
module servo_pwm_capture #(
  parameter int DIV       = 100,
  parameter int TIMEOUT_T = 25000,
  parameter int MIN_T     = 500,
  parameter int MAX_T     = 2500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        pwm_in,
  output logic [15:0] high_t,
  output logic [15:0] period_t,
  output logic        valid,
  output logic        in_range,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    HIGH,
    LOW
  } state_e;

  localparam int            PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic          s1_q, s2_q, s3_q;
  logic          rise, fall, tick, timeout_hit;
  logic [PW-1:0] pre_q, pre_d;
  state_e        state_q, state_d;
  logic [15:0]   hi_cnt_q, hi_cnt_d;
  logic [15:0]   per_cnt_q, per_cnt_d;
  logic [15:0]   hi_hold_q, hi_hold_d;
  logic [15:0]   hi_inc, per_inc;
  logic [15:0]   high_t_q, high_t_d;
  logic [15:0]   period_t_q, period_t_d;
  logic          valid_q, valid_d;
  logic          in_range_q, in_range_d;
  logic          timeout_q, timeout_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // s1/s2 resolve metastability; s3 is the one-cycle history used for edge decode.
  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= pwm_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise        = s2_q & ~s3_q;
  assign fall        = ~s2_q & s3_q;
  assign tick        = (pre_q == PRE_LAST);
  assign hi_inc      = tick ? sat_inc(hi_cnt_q) : hi_cnt_q;
  assign per_inc     = tick ? sat_inc(per_cnt_q) : per_cnt_q;
  assign timeout_hit = (int'({16'd0, per_cnt_q}) >= TIMEOUT_T);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    pre_d      = tick ? '0 : pre_q + PW'(1);
    hi_cnt_d   = hi_cnt_q;
    per_cnt_d  = per_cnt_q;
    hi_hold_d  = hi_hold_q;
    high_t_d   = high_t_q;
    period_t_d = period_t_q;
    valid_d    = 1'b0;
    in_range_d = in_range_q;
    timeout_d  = timeout_q;

    if (!enable) begin
      state_d   = IDLE;
      hi_cnt_d  = '0;
      per_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = WAIT_RISE;

        WAIT_RISE: begin
          if (rise) begin
            state_d   = HIGH;
            hi_cnt_d  = '0;
            per_cnt_d = '0;
          end
        end

        HIGH: begin
          if (timeout_hit) begin
            timeout_d = 1'b1;
            state_d   = WAIT_RISE;
            hi_cnt_d  = '0;
            per_cnt_d = '0;
          end else begin
            hi_cnt_d  = hi_inc;
            per_cnt_d = per_inc;
            if (fall) begin
              // The tick coinciding with the fall still belongs to the high phase.
              hi_hold_d = hi_inc;
              state_d   = LOW;
            end
          end
        end

        LOW: begin
          if (rise) begin
            high_t_d   = hi_hold_q;
            period_t_d = per_cnt_q;
            valid_d    = 1'b1;
            timeout_d  = 1'b0;
            in_range_d = (int'(hi_hold_q) >= MIN_T) && (int'(hi_hold_q) <= MAX_T);
            hi_cnt_d   = '0;
            per_cnt_d  = '0;
            state_d    = HIGH;
          end else if (timeout_hit) begin
            timeout_d = 1'b1;
            state_d   = WAIT_RISE;
            hi_cnt_d  = '0;
            per_cnt_d = '0;
          end else begin
            per_cnt_d = per_inc;
          end
        end

        default: state_d = IDLE;
      endcase
    end

    // Tick phase restarts at each rise so both counts are aligned to the pulse edge.
    if (rise || state_q == IDLE || state_q == WAIT_RISE) begin
      pre_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pre_q      <= '0;
      hi_cnt_q   <= '0;
      per_cnt_q  <= '0;
      hi_hold_q  <= '0;
      high_t_q   <= '0;
      period_t_q <= '0;
      valid_q    <= 1'b0;
      in_range_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      hi_cnt_q   <= hi_cnt_d;
      per_cnt_q  <= per_cnt_d;
      hi_hold_q  <= hi_hold_d;
      high_t_q   <= high_t_d;
      period_t_q <= period_t_d;
      valid_q    <= valid_d;
      in_range_q <= in_range_d;
      timeout_q  <= timeout_d;
    end
  end

  assign high_t   = high_t_q;
  assign period_t = period_t_q;
  assign valid    = valid_q;
  assign in_range = in_range_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_servo_pwm_capture.sv
// Bench for servo_pwm_capture: scaled-down main instance driven through directed
// scenarios, plus a DIV=1 instance held high to exercise counter saturation.
module tb_servo_pwm_capture;

  localparam int DIV   = 2;
  localparam int TO_T  = 2500;
  localparam int MIN_T = 50;
  localparam int MAX_T = 250;

  logic        clk = 1'b0;
  logic        reset = 1'b0, enable = 1'b0, pwm_in = 1'b0;
  logic [15:0] high_t, period_t;
  logic        valid, in_range, timeout;

  logic        reset2 = 1'b0, enable2 = 1'b0, pwm2 = 1'b0;
  logic [15:0] high_t2, period_t2;
  logic        valid2, in_range2, timeout2;

  servo_pwm_capture #(.DIV(DIV), .TIMEOUT_T(TO_T), .MIN_T(MIN_T), .MAX_T(MAX_T)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pwm_in(pwm_in),
    .high_t(high_t), .period_t(period_t), .valid(valid),
    .in_range(in_range), .timeout(timeout)
  );

  servo_pwm_capture #(.DIV(1), .TIMEOUT_T(65535)) dut_sat (
    .clk(clk), .reset(reset2), .enable(enable2), .pwm_in(pwm2),
    .high_t(high_t2), .period_t(period_t2), .valid(valid2),
    .in_range(in_range2), .timeout(timeout2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   h;
    int   p;
    logic r;
  } meas_t;

  meas_t sb[$];
  meas_t cur = '{h: 0, p: 0, r: 1'b0};
  int    n_pass = 0, n_total = 0, n_valid2 = 0, cyc = 0, t2 = 0;
  bit    armed = 1'b0;
  int    last_h = 0, last_p = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic exp_range(int h);
    return (h >= MIN_T) && (h <= MAX_T);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_near(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (!$isunknown(obs) && (obs + 1 >= exp) && (obs <= exp + 1)) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d +/-1", tag, obs, exp);
  endtask

  // Scoreboard consumer: each valid pulse must match the oldest expected measurement.
  always @(negedge clk) begin
    if (reset === 1'b1 && valid === 1'b1) begin
      check("valid_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        cur = sb.pop_front();
        check_near("high_t", high_t, cur.h);
        check_near("period_t", period_t, cur.p);
        check("in_range", in_range, cur.r);
      end
    end
    if (valid2 === 1'b1) n_valid2++;
  end

  task automatic wait_cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  // A rise closes the previous full period, so its measurement is expected now.
  task automatic start_rise();
    if (armed) sb.push_back('{h: last_h, p: last_p, r: exp_range(last_h)});
    pwm_in = 1'b1;
  endtask

  task automatic run_period(int h, int p, bit lat);
    start_rise();
    if (lat) begin
      repeat (2) @(negedge clk);
      check("lat_valid_before", valid, 0);
      @(negedge clk);
      check("lat_valid_at", valid, 1);
      wait_cycles(h * DIV - 3);
    end else begin
      wait_cycles(h * DIV);
    end
    pwm_in = 1'b0;
    wait_cycles((p - h) * DIV);
    last_h = h;
    last_p = p;
    armed  = 1'b1;
  endtask

  task automatic check_outputs_zero(string tag);
    check({tag, "_high_t"}, high_t, 0);
    check({tag, "_period_t"}, period_t, 0);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_in_range"}, in_range, 0);
    check({tag, "_timeout"}, timeout, 0);
  endtask

  task automatic check_hold(string tag, logic exp_timeout);
    check_near({tag, "_high_t"}, high_t, cur.h);
    check_near({tag, "_period_t"}, period_t, cur.p);
    check({tag, "_in_range"}, in_range, cur.r);
    check({tag, "_timeout"}, timeout, exp_timeout);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_outputs_zero("rst");
    reset   = 1'b1;
    reset2  = 1'b1;
    enable  = 1'b1;
    enable2 = 1'b1;
    wait_cycles(10);

    // Saturation instance: one rise, then stuck high for the rest of the run
    pwm2 = 1'b1;
    t2   = cyc;

    // Nominal, short (below MIN_T) and long (above MAX_T) pulses
    run_period(150, 2000, 1'b0);
    run_period(150, 2000, 1'b1);
    run_period(150, 2000, 1'b0);
    run_period(40, 2000, 1'b0);
    run_period(260, 2000, 1'b0);
    run_period(150, 2000, 1'b0);
    check("pre_timeout", timeout, 0);

    // Input held low past TIMEOUT_T: sticky flag, outputs hold
    wait_cycles(600 * DIV);
    armed = 1'b0;
    check_hold("timeout", 1'b1);

    // Enable dropped mid-period while timeout is set
    pwm_in = 1'b1;
    wait_cycles(150 * DIV);
    pwm_in = 1'b0;
    wait_cycles(500 * DIV);
    enable = 1'b0;
    wait_cycles(20);
    check_hold("en_drop_to", 1'b1);
    enable = 1'b1;
    wait_cycles(1350 * DIV - 20);

    // A complete period afterwards clears timeout with a valid
    run_period(150, 2000, 1'b0);
    check("to_kept_no_valid", timeout, 1);
    run_period(150, 2000, 1'b0);
    check("to_cleared", timeout, 0);

    // Enable dropped mid-period, then capture resumes mid-high pulse
    enable = 1'b0;
    armed  = 1'b0;
    wait_cycles(20);
    check_hold("en_drop", 1'b0);
    pwm_in = 1'b1;
    wait_cycles(50 * DIV);
    enable = 1'b1;
    wait_cycles(100 * DIV);
    pwm_in = 1'b0;
    wait_cycles(1850 * DIV);
    run_period(150, 2000, 1'b0);
    run_period(150, 2000, 1'b0);

    // Reset pulsed mid-pulse: outputs cleared at once, partial discarded
    start_rise();
    wait_cycles(100 * DIV);
    reset = 1'b0;
    #1;
    check_outputs_zero("mid_rst");
    armed = 1'b0;
    @(negedge clk);
    pwm_in = 1'b0;
    wait_cycles(10);
    reset = 1'b1;
    wait_cycles(20);
    run_period(120, 1800, 1'b0);
    check("post_rst_no_valid", high_t, 0);
    run_period(200, 2200, 1'b0);
    start_rise();
    wait_cycles(10);
    check("sb_drained", sb.size(), 0);

    // Saturation instance: timeout only once per_cnt reaches 65535
    while (cyc < t2 + 65500) @(negedge clk);
    check("sat_timeout_early", timeout2, 0);
    while (cyc < t2 + 65560) @(negedge clk);
    check("sat_timeout", timeout2, 1);
    check("sat_no_valid", n_valid2, 0);
    check("sat_high_t", high_t2, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/servo_pwm_capture.md
SERVO_PWM_CAPTURE -- requirements
Module: servo_pwm_capture

Interface
REQ-001 Parameter DIV, default 100: clk cycles per measurement tick (100 MHz clk gives 1 us per tick).
REQ-002 Parameter TIMEOUT_T, default 25000: ticks without a qualifying edge before timeout.
REQ-003 Parameter MIN_T, default 500: lower bound of the in-range high time, in ticks.
REQ-004 Parameter MAX_T, default 2500: upper bound of the in-range high time, in ticks.
REQ-005 clk  input  1  system clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  synchronous capture enable.
REQ-008 pwm_in  input  1  asynchronous servo PWM input.
REQ-009 high_t  output  16  last measured high time, in ticks.
REQ-010 period_t  output  16  last measured rise-to-rise period, in ticks.
REQ-011 valid  output  1  one-cycle pulse when high_t and period_t update.
REQ-012 in_range  output  1  MIN_T <= high_t <= MAX_T, updated together with valid.
REQ-013 timeout  output  1  sticky flag: no edge seen within TIMEOUT_T ticks.

Function
REQ-014 pwm_in SHALL pass through a 2-FF synchronizer (s1, s2) plus a history FF s3.
REQ-015 Edges SHALL be decoded as rise = s2 & ~s3 and fall = ~s2 & s3.
REQ-016 Prescaler SHALL count 0..DIV-1 and assert tick for one cycle when it equals DIV-1, then wrap to 0.
REQ-017 Prescaler SHALL be forced to 0 on every rise and whenever the state is IDLE or WAIT_RISE.
REQ-018 FSM states SHALL be IDLE, WAIT_RISE, HIGH and LOW.
REQ-019 IDLE SHALL go to WAIT_RISE when enable=1.
REQ-020 WAIT_RISE SHALL go to HIGH on rise, clearing hi_cnt and per_cnt, without asserting valid.
REQ-021 A pulse already high when capture starts SHALL be ignored until the next rise.
REQ-022 HIGH SHALL increment hi_cnt and per_cnt on each tick.
REQ-023 HIGH SHALL go to LOW on fall, latching hi_cnt into hi_hold.
REQ-024 LOW SHALL increment per_cnt on each tick.
REQ-025 On rise in LOW: high_t <= hi_hold, period_t <= per_cnt, valid=1 for one cycle, timeout <= 0.
REQ-026 On rise in LOW: in_range is evaluated on hi_hold, counters clear, state goes to HIGH.
REQ-027 If a tick and a rise occur in the same cycle, the rise SHALL win: the counter clears and does not count that tick.
REQ-028 hi_cnt and per_cnt SHALL be 16 bits and saturate at 16'hFFFF, never wrapping.
REQ-029 In HIGH or LOW, when per_cnt reaches TIMEOUT_T: timeout <= 1, state goes to WAIT_RISE, counters clear.
REQ-030 A timeout SHALL leave high_t, period_t and in_range holding their last values, with no valid pulse.
REQ-031 enable=0 in any state SHALL move the FSM to IDLE on the next edge and clear counters.
REQ-032 enable=0 SHALL leave output registers, including timeout, unchanged.
REQ-033 Latency: pwm_in first sampled high at edge N -> valid high for the cycle after edge N+2.
REQ-034 Latency: high_t/period_t update at edge N+2.
REQ-035 Measurement accuracy SHALL be +/-1 tick relative to the true high time and period.

Reset
REQ-036 reset=0 SHALL immediately force s1=s2=s3=0, prescaler=0, hi_cnt=per_cnt=hi_hold=0 and state=IDLE.
REQ-037 reset=0 SHALL immediately force high_t=0, period_t=0, valid=0, in_range=0 and timeout=0.
REQ-038 Reset asserted mid-pulse SHALL discard the partial measurement.
REQ-039 After reset release, the first valid SHALL require one complete rise-fall-rise sequence.

Verification
REQ-040 Defaults, 100 MHz clk, enable=1, 1500 us high / 20000 us period -> valid on 2nd rise onward; high_t=1500+/-1, period_t=20000+/-1, in_range=1.
REQ-041 High 400 us, then high 2600 us, period 20000 us -> in_range=0 for both; high_t=400+/-1, then 2600+/-1.
REQ-042 pwm_in held low 30 ms after valid captures -> timeout=1 at ~25000 ticks; outputs hold; next full period clears timeout with valid.
REQ-043 Capture starts mid-high pulse -> no valid at first fall; first valid only after two subsequent rises.
REQ-044 enable dropped mid-period, then raised -> no valid for the aborted period; outputs unchanged; timeout unchanged.
REQ-045 Reset pulsed mid-pulse -> all outputs 0 at once; the first valid after release needs a full rise-fall-rise.
REQ-046 pwm_in stuck high with TIMEOUT_T=16'hFFFF -> per_cnt saturates at 65535, no wrap; timeout asserts.
